// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset/lock sequencer that releases a clean system reset
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count,
    output logic [2:0] state
);

    localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);

    // Each counter leaves its state on the edge where it already holds N-1,
    // so the state lasts exactly N clock edges.
    localparam logic [PW-1:0] PULSE_LAST   = PW'(RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_ASSERT    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t        cur_state;
    state_t        next_state;
    logic          sync_meta;
    logic          lock_s;
    logic [PW-1:0] pulse_cnt;
    logic [TW-1:0] timeout_cnt;
    logic [SW-1:0] stable_cnt;
    logic          restart;
    logic          retry_inc;
    logic          retry_clr;
    logic          loss_inc;

    // Two-flop synchronizer bringing the asynchronous lock flag into refclk.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            sync_meta <= pll_locked;
            lock_s    <= sync_meta;
        end
    end

    // Next-state selection; relock_req overrides every other transition.
    always_comb begin
        next_state = cur_state;
        retry_inc  = 1'b0;
        retry_clr  = 1'b0;
        loss_inc   = 1'b0;
        if (relock_req) begin
            next_state = ST_ASSERT;
            retry_clr  = 1'b1;
        end else begin
            case (cur_state)
                ST_ASSERT: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        next_state = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    // A lock arriving on the timeout edge still wins.
                    if (lock_s) begin
                        next_state = ST_STABILIZE;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        if (retry_count == RETRY_LIMIT) begin
                            next_state = ST_FAIL;
                        end else begin
                            next_state = ST_ASSERT;
                            retry_inc  = 1'b1;
                        end
                    end
                end
                ST_STABILIZE: begin
                    // A drop on the final stabilize edge still sends us back.
                    if (!lock_s) begin
                        next_state = ST_WAIT_LOCK;
                    end else if (stable_cnt == STABLE_LAST) begin
                        next_state = ST_RUN;
                        retry_clr  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        next_state = ST_ASSERT;
                        loss_inc   = 1'b1;
                    end
                end
                ST_FAIL: begin
                    next_state = ST_FAIL;
                end
                default: begin
                    next_state = ST_ASSERT;
                end
            endcase
        end
        // Every state change (and every relock) starts its counters from zero.
        restart = relock_req || (next_state != cur_state);
    end

    // State register with outputs decoded from the next state so they are registered.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            cur_state <= ST_ASSERT;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            cur_state <= next_state;
            pll_rst   <= (next_state == ST_ASSERT) || (next_state == ST_FAIL);
            sys_rst   <= (next_state != ST_RUN);
            ready     <= (next_state == ST_RUN);
            fail      <= (next_state == ST_FAIL);
        end
    end

    // Per-state cycle counters, each only advancing while its state is held.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            pulse_cnt   <= '0;
            timeout_cnt <= '0;
            stable_cnt  <= '0;
        end else if (restart) begin
            pulse_cnt   <= '0;
            timeout_cnt <= '0;
            stable_cnt  <= '0;
        end else begin
            if (cur_state == ST_ASSERT) begin
                pulse_cnt <= pulse_cnt + 1'b1;
            end
            if (cur_state == ST_WAIT_LOCK) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end
            if (cur_state == ST_STABILIZE) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    // Retry bookkeeping and saturating count of lock losses seen while running.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            retry_count     <= 4'd0;
            lock_loss_count <= 8'd0;
        end else begin
            if (retry_clr) begin
                retry_count <= 4'd0;
            end else if (retry_inc) begin
                retry_count <= retry_count + 4'd1;
            end
            if (loss_inc && (lock_loss_count != 8'hFF)) begin
                lock_loss_count <= lock_loss_count + 8'd1;
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scoreboard bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    localparam int PULSE   = 4;
    localparam int TIMEOUT = 20;
    localparam int STABLE  = 8;
    localparam int RETRIES = 2;
    localparam logic [18:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 3'd0};

    logic       refclk     = 1'b0;
    logic       rst        = 1'b0;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES   (PULSE),
        .LOCK_TIMEOUT_CYCLES(TIMEOUT),
        .LOCK_STABLE_CYCLES (STABLE),
        .MAX_RETRIES        (RETRIES)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .relock_req     (relock_req),
        .pll_rst        (pll_rst),
        .sys_rst        (sys_rst),
        .ready          (ready),
        .fail           (fail),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count),
        .state          (state)
    );

    always #5 refclk = ~refclk;

    // Posedge n happens at 10n-5, negedge n at 10n.
    function automatic int cyc_now();
        longint t;
        t = longint'($time);
        return int'((t - 5) / 10) + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc_now());
        end
    endtask

    // ---------------- reference model (phase + time-in-phase) ----------------
    typedef struct {
        int          cyc;
        logic [18:0] vec;
    } ev_t;

    ev_t         exp_q[$];
    bit          lock_at[int];
    int          m_phase      = 0;
    int          m_elapsed    = 0;
    int          m_retries    = 0;
    int          m_losses     = 0;
    int          m_first_edge = -1;
    logic [18:0] m_last       = RESET_VEC;

    function automatic void model_enter(input int ph);
        m_phase   = ph;
        m_elapsed = 0;
    endfunction

    function automatic logic [18:0] model_vec();
        logic pr, sr, rd, fl;
        pr = (m_phase == 0) || (m_phase == 4);
        sr = (m_phase != 3);
        rd = (m_phase == 3);
        fl = (m_phase == 4);
        return {pr, sr, rd, fl, 4'(m_retries), 8'(m_losses), 3'(m_phase)};
    endfunction

    always @(posedge refclk or posedge rst) begin
        int          c;
        bit          lk;
        logic [18:0] v;
        c = cyc_now();
        if (rst) begin
            m_phase      = 0;
            m_elapsed    = 0;
            m_retries    = 0;
            m_losses     = 0;
            m_first_edge = -1;
        end else begin
            if (m_first_edge < 0) m_first_edge = c;
            lock_at[c] = pll_locked;
            lk = (c - 2 >= m_first_edge) ? lock_at[c - 2] : 1'b0;
            if (lock_at.exists(c - 4)) lock_at.delete(c - 4);
            m_elapsed++;
            if (relock_req) begin
                m_retries = 0;
                model_enter(0);
            end else begin
                case (m_phase)
                    0: if (m_elapsed == PULSE) model_enter(1);
                    1: begin
                        if (lk) model_enter(2);
                        else if (m_elapsed == TIMEOUT) begin
                            if (m_retries == RETRIES) model_enter(4);
                            else begin
                                m_retries++;
                                model_enter(0);
                            end
                        end
                    end
                    2: begin
                        if (!lk) model_enter(1);
                        else if (m_elapsed == STABLE) begin
                            m_retries = 0;
                            model_enter(3);
                        end
                    end
                    3: begin
                        if (!lk) begin
                            if (m_losses < 255) m_losses++;
                            model_enter(0);
                        end
                    end
                    default: ;
                endcase
            end
        end
        v = model_vec();
        if (v !== m_last) begin
            exp_q.push_back('{c, v});
            m_last = v;
        end
    end

    // ---------------- monitor: compares every output change ----------------
    logic [18:0] mon_prev = RESET_VEC;

    always @(negedge refclk) begin
        logic [18:0] v;
        ev_t         e;
        v = {pll_rst, sys_rst, ready, fail, retry_count, lock_loss_count, state};
        if (v !== mon_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL output_event cycle=%0d actual=%05h required=no change", cyc_now(), v);
            end else begin
                e = exp_q.pop_front();
                if ((e.cyc != cyc_now()) || (e.vec !== v)) begin
                    errors++;
                    $display("FAIL output_event cycle=%0d actual=%05h required=%05h at cycle %0d",
                             cyc_now(), v, e.vec, e.cyc);
                end
            end
            mon_prev = v;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n;
        n = 0;
        while ((state !== s) && (n < budget)) begin
            @(negedge refclk);
            n++;
        end
        chk(name, 32'(state), 32'(s));
    endtask

    task automatic pulse_relock();
        relock_req = 1'b1;
        @(negedge refclk);
        relock_req = 1'b0;
    endtask

    initial begin
        int n;
        int len;
        bit pulse_seen;

        #1 rst = 1'b1;
        repeat (3) @(negedge refclk);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_pll_rst", 32'(pll_rst), 32'd1);
        chk("reset_sys_rst", 32'(sys_rst), 32'd1);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_fail", 32'(fail), 32'd0);
        chk("reset_retry", 32'(retry_count), 32'd0);
        chk("reset_loss", 32'(lock_loss_count), 32'd0);

        // Nominal bring-up.
        rst = 1'b0;
        n = 0;
        while (pll_rst && (n < 20)) begin
            @(negedge refclk);
            n++;
        end
        chk("nominal_pulse_edges", 32'(n), 32'(PULSE));
        repeat (10) @(negedge refclk);
        pll_locked = 1'b1;
        n = 0;
        while (sys_rst && (n < 40)) begin
            @(negedge refclk);
            n++;
        end
        chk("nominal_release_delay", 32'(n), 32'(1 + 2 + STABLE));
        chk("nominal_ready", 32'(ready), 32'd1);
        chk("nominal_retry", 32'(retry_count), 32'd0);

        // Never lock: pulses every PULSE+TIMEOUT cycles, then FAIL holds pll_rst.
        pll_locked = 1'b0;
        pulse_relock();
        for (int i = 0; i < 96; i++) begin
            chk("never_lock_pll_rst", 32'(pll_rst),
                ((i >= (RETRIES + 1) * (PULSE + TIMEOUT)) || ((i % (PULSE + TIMEOUT)) < PULSE)) ? 32'd1 : 32'd0);
            @(negedge refclk);
        end
        chk("never_lock_state", 32'(state), 32'd4);
        chk("never_lock_fail", 32'(fail), 32'd1);
        chk("never_lock_sys_rst", 32'(sys_rst), 32'd1);
        chk("never_lock_retry", 32'(retry_count), 32'(RETRIES));
        pll_locked = 1'b1;
        repeat (10) @(negedge refclk);
        chk("fail_holds", 32'(state), 32'd4);
        pll_locked = 1'b0;
        pulse_relock();
        chk("relock_from_fail_state", 32'(state), 32'd0);
        chk("relock_from_fail_retry", 32'(retry_count), 32'd0);

        // Lock glitch during stabilize.
        wait_state(3'd1, 10, "glitch_wait_lock");
        pll_locked = 1'b1;
        repeat (5) @(negedge refclk);
        pll_locked = 1'b0;
        repeat (3) @(negedge refclk);
        pll_locked = 1'b1;
        pulse_seen = 1'b0;
        n = 0;
        while (!ready && (n < 60)) begin
            @(negedge refclk);
            n++;
            if (pll_rst) pulse_seen = 1'b1;
        end
        chk("glitch_no_pulse", 32'(pulse_seen), 32'd0);
        chk("glitch_release_delay", 32'(n), 32'(1 + 2 + STABLE));

        // relock_req coinciding with a lock drop in RUN.
        pll_locked = 1'b0;
        @(negedge refclk);
        relock_req = 1'b1;
        @(negedge refclk);
        relock_req = 1'b0;
        pll_locked = 1'b1;
        chk("relock_drop_state", 32'(state), 32'd0);
        chk("relock_drop_loss", 32'(lock_loss_count), 32'd0);
        wait_state(3'd3, 60, "relock_drop_rerelease");

        // Repeated one-cycle lock losses in RUN.
        for (int k = 0; k < 300; k++) begin
            pll_locked = 1'b0;
            n = 0;
            while (!sys_rst && (n < 10)) begin
                @(negedge refclk);
                n++;
                if (n == 1) pll_locked = 1'b1;
            end
            chk("loss_detect_delay", 32'(n), 32'd3);
            if (k == 0) chk("loss_first_count", 32'(lock_loss_count), 32'd1);
            wait_state(3'd3, 60, "loss_rerelease");
        end
        chk("loss_saturated", 32'(lock_loss_count), 32'd255);

        // Randomized lock activity with occasional relock requests.
        for (int r = 0; r < 60; r++) begin
            pll_locked = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 40));
            repeat (len) begin
                relock_req = ($urandom_range(0, 63) == 0);
                @(negedge refclk);
            end
            relock_req = 1'b0;
        end

        // Asynchronous reset in the middle of stabilize.
        pll_locked = 1'b1;
        pulse_relock();
        wait_state(3'd2, 40, "rst_reach_stabilize");
        @(posedge refclk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_pll_rst", 32'(pll_rst), 32'd1);
        chk("async_rst_sys_rst", 32'(sys_rst), 32'd1);
        chk("async_rst_ready", 32'(ready), 32'd0);
        chk("async_rst_fail", 32'(fail), 32'd0);
        chk("async_rst_retry", 32'(retry_count), 32'd0);
        chk("async_rst_loss", 32'(lock_loss_count), 32'd0);
        repeat (3) @(negedge refclk);
        rst = 1'b0;
        wait_state(3'd3, 60, "post_rst_release");

        repeat (3) @(negedge refclk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
